// File: rtl/bsg_mem_1r1w_sync_mask_clear_pkg.sv
// Shared types and helpers for bsg_mem_1r1w_sync_mask_clear.
// The masked-merge helper works on a fixed maximum word width so both the
// write path and the forward path can share it for any width_p up to
// max_width_lp; callers zero-extend into it and truncate the result.
package bsg_mem_1r1w_sync_mask_clear_pkg;

    localparam int max_width_lp = 1024;

    typedef logic [max_width_lp-1:0] max_word_t;

    typedef enum logic {
        eClear,
        eReady
    } state_e;

    // Keep old bits where the expanded mask is 0, take new bits where it is 1.
    function automatic max_word_t masked_merge(input max_word_t old_word,
                                               input max_word_t new_word,
                                               input max_word_t bit_mask);
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/bsg_mem_init_sweeper.sv
// Post-reset clear sequencer: walks every entry once, driving a zero-write
// enable and address, then parks in eReady and raises init_done_o.
module bsg_mem_init_sweeper
    import bsg_mem_1r1w_sync_mask_clear_pkg::*;
#(
    parameter int els_p         = 16,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     sweep_v_o,
    output logic [addr_width_lp-1:0] sweep_addr_o,
    output logic                     init_done_o
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   state_r;
    logic [addr_width_lp-1:0] count_r;

    // Sweep FSM: reset restarts from entry 0; the last entry's write moves to eReady.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset_i) begin
            state_r <= eClear;
            count_r <= '0;
        end else if (state_r == eClear) begin
            if (count_r == last_addr_lp) begin
                state_r <= eReady;
                count_r <= '0;
            end else begin
                count_r <= count_r + addr_width_lp'(1);
            end
        end
    end

    // Zero-writes only happen in cycles where reset is released.
    assign sweep_v_o    = (state_r == eClear) && !reset_i;
    assign sweep_addr_o = count_r;
    assign init_done_o  = (state_r == eReady);

endmodule

// File: rtl/bsg_mem_1r1w_sync_mask_clear.sv
// 1R1W RAM with registered read, per-segment write mask and zero-clear
// sweep after reset. Word width must not exceed max_width_lp of the package.
// Optional macro BSG_MEM_1R1W_SYNC_FWD_EN: when defined, a same-cycle,
// same-address read returns the freshly merged word (write-first); when
// undefined the read returns the word before the write (read-first).
module bsg_mem_1r1w_sync_mask_clear
    import bsg_mem_1r1w_sync_mask_clear_pkg::*;
#(
    // width_p and els_p are expected to be overridden by every instance.
    parameter int width_p       = 32,
    parameter int els_p         = 16,
    parameter int mask_width_p  = 1,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int seg_width_lp  = width_p / mask_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     init_done_o,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [mask_width_p-1:0]  w_mask_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o,
    output logic                     r_v_o
);

    logic [width_p-1:0]       mem_r [els_p];
    logic                     sweep_v;
    logic [addr_width_lp-1:0] sweep_addr;
    logic [width_p-1:0]       bit_mask;
    logic [width_p-1:0]       merged_word;
    logic [width_p-1:0]       read_word;

    bsg_mem_init_sweeper #(
        .els_p         (els_p),
        .addr_width_lp (addr_width_lp)
    ) sweeper (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .sweep_v_o    (sweep_v),
        .sweep_addr_o (sweep_addr),
        .init_done_o  (init_done_o)
    );

    // Expand each mask bit across its segment.
    always_comb begin
        // NOTE: default first so no path leaves bit_mask unassigned (no latch).
        bit_mask = '0;
        for (int i = 0; i < mask_width_p; i++) begin
            bit_mask[i*seg_width_lp +: seg_width_lp] = {seg_width_lp{w_mask_i[i]}};
        end
    end

    assign merged_word = width_p'(masked_merge(max_word_t'(mem_r[w_addr_i]),
                                               max_word_t'(w_data_i),
                                               max_word_t'(bit_mask)));

`ifdef BSG_MEM_1R1W_SYNC_FWD_EN
    // Write-first: a colliding write's merged word bypasses the array.
    assign read_word = (w_v_i && (w_addr_i == r_addr_i)) ? merged_word : mem_r[r_addr_i];
`else
    // Read-first: the array word as it stood before this cycle's write.
    assign read_word = mem_r[r_addr_i];
`endif

    // Storage: sweep zero-writes during eClear, masked user writes in eReady.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; the sweep is what clears it.
        if (sweep_v) begin
            mem_r[sweep_addr] <= '0;
        end else if (init_done_o && w_v_i) begin
            mem_r[w_addr_i] <= merged_word;
        end
    end

    // Registered read port; reads are ignored until the sweep completes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data_o <= '0;
            r_v_o    <= 1'b0;
        end else if (!init_done_o) begin
            r_v_o    <= 1'b0;
        end else begin
            r_v_o <= r_v_i;
            if (r_v_i) begin
                r_data_o <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_clear.sv
// Directed bench for bsg_mem_1r1w_sync_mask_clear (32b x 16, 4 mask bits).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_bsg_mem_1r1w_sync_mask_clear;

    localparam int width_p      = 32;
    localparam int els_p        = 16;
    localparam int mask_width_p = 4;
    localparam int aw_lp        = 4;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic                    init_done_o;
    logic                    w_v_i;
    logic [aw_lp-1:0]        w_addr_i;
    logic [width_p-1:0]      w_data_i;
    logic [mask_width_p-1:0] w_mask_i;
    logic                    r_v_i;
    logic [aw_lp-1:0]        r_addr_i;
    logic [width_p-1:0]      r_data_o;
    logic                    r_v_o;

    int vectors = 0;
    int errors  = 0;

    bsg_mem_1r1w_sync_mask_clear #(
        .width_p      (width_p),
        .els_p        (els_p),
        .mask_width_p (mask_width_p)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .init_done_o (init_done_o),
        .w_v_i       (w_v_i),
        .w_addr_i    (w_addr_i),
        .w_data_i    (w_data_i),
        .w_mask_i    (w_mask_i),
        .r_v_i       (r_v_i),
        .r_addr_i    (r_addr_i),
        .r_data_o    (r_data_o),
        .r_v_o       (r_v_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [aw_lp-1:0] a, input logic [31:0] d, input logic [3:0] m);
        w_v_i = 1'b1; w_addr_i = a; w_data_i = d; w_mask_i = m;
        step();
        w_v_i = 1'b0;
    endtask

    task automatic rd(input logic [aw_lp-1:0] a, output logic [31:0] d, output logic v);
        r_v_i = 1'b1; r_addr_i = a;
        step();
        r_v_i = 1'b0;
        d = r_data_o;
        v = r_v_o;
    endtask

    // Counts cycles with init_done_o low (bounded); used after releasing reset.
    task automatic wait_init(output int lows);
        lows = 0;
        while (!init_done_o && lows < 40) begin
            lows++;
            step();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_collide;
        int          lows;
        int          rv_bad;

        reset_i = 1'b1; w_v_i = 1'b0; w_addr_i = '0; w_data_i = '0; w_mask_i = '0;
        r_v_i = 1'b0; r_addr_i = '0;
        repeat (3) step();
        check("reset_init_done", 32'(init_done_o), 32'h0);
        check("reset_r_v", 32'(r_v_o), 32'h0);
        check("reset_r_data", r_data_o, 32'h0);

        // Release; hammer entry 1 with writes and reads throughout the sweep.
        reset_i = 1'b0;
        lows = 0; rv_bad = 0;
        while (!init_done_o && lows < 40) begin
            w_v_i = 1'b1; w_addr_i = 4'd1; w_data_i = 32'hFFFF_FFFF; w_mask_i = 4'hF;
            r_v_i = 1'b1; r_addr_i = 4'd1;
            lows++;
            step();
            if (r_v_o) rv_bad++;
        end
        w_v_i = 1'b0; r_v_i = 1'b0;
        check("sweep_low_cycles", 32'(lows), 32'd16);
        check("sweep_init_done", 32'(init_done_o), 32'h1);
        check("sweep_r_v_quiet", 32'(rv_bad), 32'h0);

        for (int a = 0; a < els_p; a++) begin
            rd(aw_lp'(a), d, v);
            check($sformatf("clear_data[%0d]", a), d, 32'h0);
            check($sformatf("clear_v[%0d]", a), 32'(v), 32'h1);
        end

        // Masked merge.
        wr(4'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(4'd5, 32'h1122_3344, 4'b0101);
        rd(4'd5, d, v);
        check("mask_merge", d, 32'hDE22_BE44);
        wr(4'd5, 32'h0000_0000, 4'b0000);
        rd(4'd5, d, v);
        check("mask_zero_noop", d, 32'hDE22_BE44);

        // Same-cycle, same-address collision on entry 3 (currently 0).
`ifdef BSG_MEM_1R1W_SYNC_FWD_EN
        exp_collide = 32'hCAFE_F00D;
`else
        exp_collide = 32'h0000_0000;
`endif
        w_v_i = 1'b1; w_addr_i = 4'd3; w_data_i = 32'hCAFE_F00D; w_mask_i = 4'hF;
        r_v_i = 1'b1; r_addr_i = 4'd3;
        step();
        w_v_i = 1'b0; r_v_i = 1'b0;
        check("collide_data", r_data_o, exp_collide);
        check("collide_v", 32'(r_v_o), 32'h1);
        rd(4'd3, d, v);
        check("collide_after", d, 32'hCAFE_F00D);

        // Different addresses in one cycle are independent.
        w_v_i = 1'b1; w_addr_i = 4'd9; w_data_i = 32'h1234_5678; w_mask_i = 4'hF;
        r_v_i = 1'b1; r_addr_i = 4'd5;
        step();
        w_v_i = 1'b0; r_v_i = 1'b0;
        check("indep_read", r_data_o, 32'hDE22_BE44);
        rd(4'd9, d, v);
        check("indep_write", d, 32'h1234_5678);

        // Read hold: r_data_o keeps its value, r_v_o pulses once.
        wr(4'd7, 32'h0BAD_F00D, 4'hF);
        rd(4'd7, d, v);
        check("hold_first_data", d, 32'h0BAD_F00D);
        check("hold_first_v", 32'(v), 32'h1);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("hold_data[%0d]", c), r_data_o, 32'h0BAD_F00D);
            check($sformatf("hold_v[%0d]", c), 32'(r_v_o), 32'h0);
        end

        // Fill everything with ones.
        for (int a = 0; a < els_p; a++) wr(aw_lp'(a), 32'hFFFF_FFFF, 4'hF);
        rd(4'd12, d, v);
        check("fill_ones", d, 32'hFFFF_FFFF);

        // Reset with a read in flight: the read is dropped.
        reset_i = 1'b1; r_v_i = 1'b1; r_addr_i = 4'd2;
        step();
        r_v_i = 1'b0;
        check("drop_r_v", 32'(r_v_o), 32'h0);
        check("drop_r_data", r_data_o, 32'h0);
        step();
        reset_i = 1'b0;
        repeat (9) step();
        check("mid_sweep_not_done", 32'(init_done_o), 32'h0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        wait_init(lows);
        check("resweep_low_cycles", 32'(lows), 32'd16);
        check("resweep_init_done", 32'(init_done_o), 32'h1);
        for (int a = 0; a < els_p; a++) begin
            rd(aw_lp'(a), d, v);
            check($sformatf("resweep_data[%0d]", a), d, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
